// File: rtl/pp_gen_seq.sv
// Sequential partial-product generator: captures one X/Y pair, then streams the WIDTH
// partial-product rows ROWS_PER_BEAT at a time, optionally in Baugh-Wooley signed form.
module pp_gen_seq #(
   parameter int WIDTH         = 16,
   parameter int ROWS_PER_BEAT = 4,
   parameter bit SIGNED_EN     = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WIDTH-1:0]                 x,
   input  logic [WIDTH-1:0]                 y,
   input  logic                             signed_mode,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ROWS_PER_BEAT*WIDTH-1:0]   out_rows,
   output logic [$clog2(WIDTH)-1:0]         out_row_idx,
   output logic                             out_last,
   output logic                             out_signed,
   output logic                             fsm_state
);

   localparam int IW    = $clog2(WIDTH);
   localparam int RW    = ROWS_PER_BEAT * WIDTH;
   localparam int BEATS = WIDTH / ROWS_PER_BEAT;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   if ((WIDTH % ROWS_PER_BEAT) != 0) begin : g_bad_rows_per_beat
      $error("pp_gen_seq: ROWS_PER_BEAT must divide WIDTH");
   end

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t            state;
   logic [WIDTH-1:0]  x_reg;
   logic [WIDTH-1:0]  y_reg;
   logic              sign_reg;
   logic [BW-1:0]     beat;
   logic [BW-1:0]     beat_nxt;
   logic              sign_in;

   // Row i: unsigned x[i] ? y : 0. Signed rows invert the sign-column bit, and the
   // top row inverts its magnitude bits instead (Baugh-Wooley form).
   function automatic logic [WIDTH-1:0] pp_row(input logic [WIDTH-1:0] xv,
                                               input logic [WIDTH-1:0] yv,
                                               input logic             sm,
                                               input logic [IW-1:0]    i);
      logic [WIDTH-1:0] row;
      row = xv[i] ? yv : '0;
      if (sm) begin
         if (i == IW'(WIDTH - 1)) begin
            row = {xv[WIDTH-1] & yv[WIDTH-1],
                   ~({(WIDTH-1){xv[WIDTH-1]}} & yv[WIDTH-2:0])};
         end else begin
            row[WIDTH-1] = ~(xv[i] & yv[WIDTH-1]);
         end
      end
      return row;
   endfunction

   function automatic logic [RW-1:0] beat_rows(input logic [WIDTH-1:0] xv,
                                               input logic [WIDTH-1:0] yv,
                                               input logic             sm,
                                               input logic [BW-1:0]    b);
      logic [RW-1:0] rows;
      rows = '0;
      for (int k = 0; k < ROWS_PER_BEAT; k++) begin
         rows[k*WIDTH +: WIDTH] = pp_row(xv, yv, sm, IW'(int'(b) * ROWS_PER_BEAT + k));
      end
      return rows;
   endfunction

   function automatic logic [IW-1:0] first_row(input logic [BW-1:0] b);
      return IW'(int'(b) * ROWS_PER_BEAT);
   endfunction

   assign sign_in   = SIGNED_EN & signed_mode;
   assign beat_nxt  = beat + 1'b1;
   assign fsm_state = (state == EMIT);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
   // in_ready is high only in IDLE; out_valid only in EMIT, where the beat is held until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_signed  <= 1'b0;
         out_row_idx <= '0;
         out_rows    <= '0;
         x_reg       <= '0;
         y_reg       <= '0;
         sign_reg    <= 1'b0;
         beat        <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  x_reg       <= x;
                  y_reg       <= y;
                  sign_reg    <= sign_in;
                  out_signed  <= sign_in;
                  beat        <= '0;
                  out_rows    <= beat_rows(x, y, sign_in, '0);
                  out_row_idx <= '0;
                  out_last    <= (BEATS == 1);
                  out_valid   <= 1'b1;
                  in_ready    <= 1'b0;
                  state       <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (beat == LAST_BEAT) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     in_ready  <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     beat        <= beat_nxt;
                     out_rows    <= beat_rows(x_reg, y_reg, sign_reg, beat_nxt);
                     out_row_idx <= first_row(beat_nxt);
                     out_last    <= (beat_nxt == LAST_BEAT);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pp_gen_seq.sv
// Bench for pp_gen_seq: a signed-capable instance and a SIGNED_EN=0 instance share stimulus;
// a monitor pops expected beats and pair products from queues on every output transfer.
module tb_pp_gen_seq;

   localparam int W   = 16;
   localparam int RPB = 4;
   localparam int EW  = 70;   // {signed, last, idx[3:0], rows[63:0]}

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  x = '0;
   logic [W-1:0]  y = '0;
   logic          signed_mode = 1'b0;
   logic          out_ready = 1'b1;

   logic          in_ready_a, out_valid_a, out_last_a, out_signed_a, state_a;
   logic [63:0]   out_rows_a;
   logic [3:0]    out_row_idx_a;
   logic          in_ready_b, out_valid_b, out_last_b, out_signed_b, state_b;
   logic [63:0]   out_rows_b;
   logic [3:0]    out_row_idx_b;

   logic [EW-1:0] exp_a_q[$];
   logic [EW-1:0] exp_b_q[$];
   logic [31:0]   prod_q[$];

   int            checks = 0;
   int            failures = 0;
   logic          ready_rand = 1'b0;

   pp_gen_seq #(.WIDTH(W), .ROWS_PER_BEAT(RPB), .SIGNED_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .x(x), .y(y), .signed_mode(signed_mode),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_rows(out_rows_a),
      .out_row_idx(out_row_idx_a), .out_last(out_last_a), .out_signed(out_signed_a),
      .fsm_state(state_a)
   );

   pp_gen_seq #(.WIDTH(W), .ROWS_PER_BEAT(RPB), .SIGNED_EN(1'b0)) u_dut_uns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .x(x), .y(y), .signed_mode(signed_mode),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_rows(out_rows_b),
      .out_row_idx(out_row_idx_b), .out_last(out_last_b), .out_signed(out_signed_b),
      .fsm_state(state_b)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_beat(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                              input logic sm, input int b);
      logic [63:0] rows;
      rows = '0;
      for (int k = 0; k < RPB; k++) begin
         int i;
         i = b * RPB + k;
         for (int j = 0; j < W; j++) begin
            if (sm && i == W - 1)
               rows[k*W + j] = (j == W - 1) ? (xv[W-1] & yv[W-1]) : ~(xv[W-1] & yv[j]);
            else if (sm && j == W - 1)
               rows[k*W + j] = ~(xv[i] & yv[W-1]);
            else
               rows[k*W + j] = xv[i] & yv[j];
         end
      end
      return rows;
   endfunction

   task automatic push_beat(input logic [EW-1:0] ea, input logic [EW-1:0] eb);
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
   endtask

   task automatic push_model(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sm);
      logic signed [31:0] sp;
      for (int b = 0; b < W / RPB; b++) begin
         push_beat({sm, b == W / RPB - 1, 4'(b * RPB), model_beat(xv, yv, sm, b)},
                   {1'b0, b == W / RPB - 1, 4'(b * RPB), model_beat(xv, yv, 1'b0, b)});
      end
      sp = $signed(xv) * $signed(yv);
      prod_q.push_back(sm ? 32'(sp) : ({16'b0, xv} * {16'b0, yv}));
   endtask

   // ---------------- driver ----------------
   task automatic drive_pair(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sm);
      bit seen;
      seen = 0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (in_ready_a) seen = 1;
      end
      if (!seen) begin
         check("wait_in_ready", 0, 1);
         return;
      end
      @(posedge clk); #1;
      x = xv; y = yv; signed_mode = sm; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("first_beat_latency", {out_valid_a, in_ready_a}, 2'b10);
   endtask

   task automatic wait_idle();
      bit seen;
      seen = 0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         if (in_ready_a && !out_valid_a) seen = 1;
      end
      check("return_to_idle", seen, 1);
   endtask

   always @(posedge clk) begin
      if (ready_rand) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [31:0]   sum_a = '0;
   logic          held = 1'b0;
   logic [68:0]   held_val = '0;

   always @(negedge clk) begin
      if (rst) begin
         sum_a = '0;
         held  = 1'b0;
      end else begin
         if (held)
            check("stall_hold", {out_valid_a, out_last_a, out_row_idx_a, out_rows_a}, {1'b1, held_val});
         held     = out_valid_a && !out_ready;
         held_val = {out_last_a, out_row_idx_a, out_rows_a};
         if (out_valid_a && out_ready) begin
            if (exp_a_q.size() == 0) begin
               check("unexpected_beat", {out_signed_a, out_last_a, out_row_idx_a, out_rows_a}, '0);
            end else begin
               check("beat_signed_inst", {out_signed_a, out_last_a, out_row_idx_a, out_rows_a},
                     exp_a_q.pop_front());
               for (int k = 0; k < RPB; k++)
                  sum_a = sum_a + ({16'b0, out_rows_a[k*W +: W]} << (32'(out_row_idx_a) + k));
               if (out_last_a) begin
                  if (out_signed_a) sum_a = sum_a + 32'h8001_0000;
                  if (prod_q.size() == 0) check("product_missing", 1, 0);
                  else check("product_sum", sum_a, prod_q.pop_front());
                  sum_a = '0;
               end
            end
         end
         if (out_valid_b && out_ready) begin
            if (exp_b_q.size() == 0)
               check("unexpected_beat_uns", {out_signed_b, out_last_b, out_row_idx_b, out_rows_b}, '0);
            else
               check("beat_unsigned_inst", {out_signed_b, out_last_b, out_row_idx_b, out_rows_b},
                     exp_b_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs_a", {in_ready_a, out_valid_a, out_last_a, out_signed_a, out_row_idx_a, out_rows_a}, '0);
      check("reset_outputs_b", {in_ready_b, out_valid_b, out_last_b, out_signed_b, out_row_idx_b, out_rows_b}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("in_ready_after_reset", in_ready_a, 1);

      // unsigned 0x0005 * 0x1234
      push_beat({1'b0, 1'b0, 4'd0, 64'h0000_1234_0000_1234}, {1'b0, 1'b0, 4'd0, 64'h0000_1234_0000_1234});
      push_beat({1'b0, 1'b0, 4'd4, 64'h0}, {1'b0, 1'b0, 4'd4, 64'h0});
      push_beat({1'b0, 1'b0, 4'd8, 64'h0}, {1'b0, 1'b0, 4'd8, 64'h0});
      push_beat({1'b0, 1'b1, 4'd12, 64'h0}, {1'b0, 1'b1, 4'd12, 64'h0});
      prod_q.push_back(32'h0000_5B04);
      drive_pair(16'h0005, 16'h1234, 1'b0);
      wait_idle();

      // signed -1 * 1; the SIGNED_EN=0 instance must stay unsigned
      for (int b = 0; b < 3; b++)
         push_beat({1'b1, 1'b0, 4'(b * 4), 64'h8001_8001_8001_8001},
                   {1'b0, 1'b0, 4'(b * 4), 64'h0001_0001_0001_0001});
      push_beat({1'b1, 1'b1, 4'd12, 64'h7FFE_8001_8001_8001}, {1'b0, 1'b1, 4'd12, 64'h0001_0001_0001_0001});
      prod_q.push_back(32'hFFFF_FFFF);
      drive_pair(16'hFFFF, 16'h0001, 1'b1);
      wait_idle();

      // five-cycle stall on beat 2
      push_model(16'hA5C3, 16'h3C5A, 1'b0);
      drive_pair(16'hA5C3, 16'h3C5A, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_idx", {out_valid_a, out_row_idx_a}, {1'b1, 4'd8});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("beat3_after_stall", {out_valid_a, out_last_a, out_row_idx_a}, {1'b1, 1'b1, 4'd12});
      wait_idle();

      // in_valid raised during EMIT with a different pair must be ignored
      push_model(16'h0003, 16'h00F0, 1'b0);
      drive_pair(16'h0003, 16'h00F0, 1'b0);
      @(posedge clk); #1;
      x = 16'hFFFF; y = 16'hFFFF; signed_mode = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_idle();

      // reset during beat 1 drops the pair
      push_model(16'h00FF, 16'h0F0F, 1'b1);
      drive_pair(16'h00FF, 16'h0F0F, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_a_q.delete(); exp_b_q.delete(); prod_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_emit_outputs", {out_valid_a, in_ready_a, out_valid_b, in_ready_b}, 4'b0000);
      @(posedge clk); @(negedge clk);
      check("rst_mid_emit_ready", {in_ready_a, in_ready_b}, 2'b11);
      push_model(16'h1357, 16'h2468, 1'b0);
      drive_pair(16'h1357, 16'h2468, 1'b0);
      wait_idle();

      // directed corner pairs under random back-pressure
      @(negedge clk);
      ready_rand = 1'b1;
      push_model(16'h8000, 16'h8000, 1'b1); drive_pair(16'h8000, 16'h8000, 1'b1); wait_idle();
      push_model(16'h7FFF, 16'h8000, 1'b1); drive_pair(16'h7FFF, 16'h8000, 1'b1); wait_idle();
      push_model(16'hFFFF, 16'hFFFF, 1'b0); drive_pair(16'hFFFF, 16'hFFFF, 1'b0); wait_idle();
      push_model(16'h1234, 16'hFEDC, 1'b1); drive_pair(16'h1234, 16'hFEDC, 1'b1); wait_idle();
      push_model(16'h0001, 16'h8000, 1'b1); drive_pair(16'h0001, 16'h8000, 1'b1); wait_idle();
      push_model(16'hFFFF, 16'hFFFF, 1'b1); drive_pair(16'hFFFF, 16'hFFFF, 1'b1); wait_idle();
      @(negedge clk);
      ready_rand = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      check("queues_drained", EW'(exp_a_q.size() + exp_b_q.size() + prod_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
